// File: rtl/ieee_uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
// No logic, so no latency.
// No flow control, so no backpressure.
package ieee_uart_pkg;

    // Frame-level states. The transmitter uses the same state set.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // 100 MHz core clock divided down to 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // The line is high when no frame is being sent.
    localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit, with a selectable reset value.
// Latency: 2 cycles from i_d to o_q.
// Backpressure: none; the flops sample i_d on every cycle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture. The first stage may go metastable; the second settles it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rx_ieee.sv
// UART receiver: start + DATA_BITS (LSB first) [+ even parity] + stop. Each bit is sampled at mid-period.
// Latency: about (DATA_BITS+1.5+P)*CLKS_PER_BIT + 4 cycles from the start edge at the pin to rx_valid.
// Backpressure: none. rx_valid is a one-cycle pulse and rx_data is held until the next good frame.
// Optional build macro RX_IEEE_PARITY_EN adds the PARITY state and makes rx_parity_err live.
module rx_ieee
    import ieee_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,  // minimum 4
    parameter int DATA_BITS    = 8                      // legal range 5..8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [CW-1:0]        r_baud;
    logic [CW-1:0]        w_baud_nxt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_rx_prev;
    logic                 w_rx_sync;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;
`ifdef RX_IEEE_PARITY_EN
    logic                 r_par_bad;
    logic                 r_parity_err;
    logic                 w_perr_nxt;
    logic                 w_par_sample;
`endif

    // The line idles high, so the synchronizer resets high. Otherwise reset release would look like an edge.
    sync_2ff #(
        .RST_VAL (UART_IDLE_LVL)
    ) u_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (rx),
        .o_q   (w_rx_sync)
    );

    // Keep the previous synchronized level so that only a high-to-low transition starts a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_prev <= UART_IDLE_LVL;
        end else begin
            r_rx_prev <= w_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~w_rx_sync;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, baud counting, sample strobes and the next values of the result pulses.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud + 1'b1;
        w_sample     = 1'b0;
        w_valid_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;
`ifdef RX_IEEE_PARITY_EN
        w_perr_nxt   = 1'b0;
        w_par_sample = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // Check again at mid-start. A line that is already high again was a glitch.
                if (r_baud == HALF_M1) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = w_rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nxt = '0;
                    w_sample   = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef RX_IEEE_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef RX_IEEE_PARITY_EN
            PARITY: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nxt   = '0;
                    w_par_sample = 1'b1;
                    w_state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop. The half bit that remains is slack for catching the next start edge.
                if (r_baud == FULL_M1) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_sync) begin
                        w_valid_nxt = 1'b1;
`ifdef RX_IEEE_PARITY_EN
                        w_perr_nxt  = r_par_bad;
`endif
                    end else begin
                        w_ferr_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Baud counter, bit counter and shift register. Each new bit enters at the MSB, so the first bit ends at the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_baud <= w_baud_nxt;
            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_shift   <= {w_rx_sync, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

`ifdef RX_IEEE_PARITY_EN
    // Even parity: the data bits and the parity bit together must hold an even number of ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_sample) begin
                r_par_bad <= ^{r_shift, w_rx_sync};
            end
            r_parity_err <= w_perr_nxt;
        end
    end

    assign rx_parity_err = r_parity_err;
`else
    assign rx_parity_err = 1'b0;
`endif

    // Registered result pulses. rx_data loads only on a good stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
            if (w_valid_nxt) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rx_ieee.sv
`timescale 1ns/1ps
module tb_rx_ieee;

    localparam int CPB = 10;
`ifdef RX_IEEE_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Pin start edge to the monitor seeing rx_valid: 97 rising edges plus half a cycle, plus one bit with parity.
    localparam int LAT_NOM = 98 + (FRAME_BITS - 10) * CPB;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;

    int n_valid = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    int n_both  = 0;
    int n_busy  = 0;
    time        valid_t [0:63];
    logic [7:0] valid_d [0:63];
    time        t_start;

    always #5 clk = ~clk;

    rx_ieee #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_busy       (rx_busy)
    );

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (n_valid < 64) begin
                valid_t[n_valid] = $time;
                valid_d[n_valid] = rx_data;
            end
            n_valid++;
        end
        if (rx_frame_err === 1'b1) n_ferr++;
        if (rx_parity_err === 1'b1) n_perr++;
        if (rx_valid === 1'b1 && rx_parity_err === 1'b1) n_both++;
        if (rx_busy === 1'b1) n_busy++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit-bang one frame. reset is pulsed for one cycle at cycle index rst_at (-1 means never).
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit, input int rst_at);
        logic [10:0] bits;
        int k;
        k    = 0;
        bits = {stop_bit, par_bit, d, 1'b0};
`ifndef RX_IEEE_PARITY_EN
        bits = {par_bit, stop_bit, d, 1'b0};
`endif
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                rx    = bits[b];
                reset = (k == rst_at);
                if (k == 0) t_start = $time;
                k++;
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        wait_cycles(3);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
        checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b want 0", rx_parity_err); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", rx_data); end
        reset = 1'b0;
        wait_cycles(10);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_single;
        int v0, f0, lat;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        wait_cycles(15);
        checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL single_count: got %0d want 1", n_valid - v0); end
        checks++; if (valid_d[v0] !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", valid_d[v0]); end
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL single_ferr: got %0d want 0", n_ferr - f0); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b want 0", rx_busy); end
        lat = int'((valid_t[v0] - t_start) / 10);
        checks++; if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin failures++; $display("FAIL single_latency: got %0d want %0d+-2", lat, LAT_NOM); end
    endtask

    task automatic test_back_to_back;
        int v0, f0, gap;
        logic [7:0] exp_d [0:2];
        exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h3C;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        wait_cycles(15);
        checks++; if (n_valid - v0 != 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", n_valid - v0); end
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL b2b_ferr: got %0d want 0", n_ferr - f0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (valid_d[v0 + i] !== exp_d[i]) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", i, valid_d[v0 + i], exp_d[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            gap = int'((valid_t[v0 + i] - valid_t[v0 + i - 1]) / 10);
            checks++; if (gap < FRAME_BITS * CPB - 2 || gap > FRAME_BITS * CPB + 2) begin failures++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, gap, FRAME_BITS * CPB); end
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        @(negedge clk); rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(1);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_start: got %b want 1", rx_busy); end
        wait_cycles(4);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_idle_8: got %b want 0", rx_busy); end
        wait_cycles(20);
        checks++; if (n_valid - v0 != 0) begin failures++; $display("FAIL glitch_valid: got %0d want 0", n_valid - v0); end
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
    endtask

    task automatic test_frame_err;
        int v0, f0, b0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0, -1);
        wait_cycles(2);
        b0 = n_busy;
        wait_cycles(48);
        checks++; if (n_ferr - f0 != 1) begin failures++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
        checks++; if (n_valid - v0 != 0) begin failures++; $display("FAIL ferr_valid: got %0d want 0", n_valid - v0); end
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_data_held: got %h want 3c", rx_data); end
        checks++; if (n_busy - b0 != 0) begin failures++; $display("FAIL ferr_no_retrigger: got %0d busy cycles want 0", n_busy - b0); end
        rx = 1'b1;
        wait_cycles(20);
        send_frame(8'h12, 1'b0, 1'b1, -1);
        wait_cycles(15);
        checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL ferr_recover_count: got %0d want 1", n_valid - v0); end
        checks++; if (rx_data !== 8'h12) begin failures++; $display("FAIL ferr_recover_data: got %h want 12", rx_data); end
        checks++; if (n_ferr - f0 != 1) begin failures++; $display("FAIL ferr_recover_ferr: got %0d want 1", n_ferr - f0); end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        // Cycle 83 falls inside data bit 7, which is high for 0x81.
        send_frame(8'h81, 1'b1, 1'b1, 83);
        wait_cycles(15);
        checks++; if (n_valid - v0 != 0) begin failures++; $display("FAIL rstmid_valid: got %0d want 0", n_valid - v0); end
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL rstmid_ferr: got %0d want 0", n_ferr - f0); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        send_frame(8'h42, 1'b0, 1'b1, -1);
        wait_cycles(15);
        checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL rstmid_next_count: got %0d want 1", n_valid - v0); end
        checks++; if (rx_data !== 8'h42) begin failures++; $display("FAIL rstmid_next_data: got %h want 42", rx_data); end
    endtask

`ifdef RX_IEEE_PARITY_EN
    task automatic test_parity;
        int v0, p0, b0;
        v0 = n_valid; p0 = n_perr; b0 = n_both;
        send_frame(8'h07, 1'b0, 1'b1, -1);
        wait_cycles(15);
        checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL par_bad_valid: got %0d want 1", n_valid - v0); end
        checks++; if (n_both - b0 != 1) begin failures++; $display("FAIL par_bad_together: got %0d want 1", n_both - b0); end
        checks++; if (rx_data !== 8'h07) begin failures++; $display("FAIL par_bad_data: got %h want 07", rx_data); end
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, -1);
        wait_cycles(15);
        checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL par_good_valid: got %0d want 1", n_valid - v0); end
        checks++; if (n_perr - p0 != 0) begin failures++; $display("FAIL par_good_perr: got %0d want 0", n_perr - p0); end
    endtask
`else
    task automatic test_parity;
        checks++; if (n_perr != 0) begin failures++; $display("FAIL par_tied_zero: got %0d pulses want 0", n_perr); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_ieee.md
# rx_ieee

UART receiver paired with the team's serial transmitter, `TX_IEEE`: it recovers bytes from the single-wire `rx` line using the same 8-N-1 framing and bit period. It synchronizes the asynchronous line, finds the start bit, samples each bit at mid-period and presents each byte with a one-cycle valid strobe. It sits at the pin-facing edge of the design, feeding any byte consumer, and serves as the loopback checker for the transmitter.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); minimum 4.
- `DATA_BITS`, 8, data bits per frame, sent LSB first; legal range 5..8.
- `clk  in  1  system clock; all logic is on the rising edge`
- `reset  in  1  asynchronous, active-high reset`
- `rx  in  1  serial line; idle high; asynchronous to clk`
- `rx_data  out  DATA_BITS  last received byte; held until the next valid frame`
- `rx_valid  out  1  one-cycle pulse; rx_data is new`
- `rx_frame_err  out  1  one-cycle pulse; stop bit sampled low`
- `rx_parity_err  out  1  one-cycle pulse; parity mismatch (tied 0 unless parity is compiled in)`
- `rx_busy  out  1  high in every state except IDLE`

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. A third flop, `rx_prev`, holds the previous synchronized value.
- States: IDLE, START, DATA, PARITY (present only when parity is compiled in), STOP.
- IDLE -> START when the synchronized line is 0 and `rx_prev` is 1. This is a falling edge; a line that stays low never retriggers. The bit counter clears.
- START: count to `CLKS_PER_BIT/2 - 1` (integer division) to reach mid-start, then sample.
  - Sample 1: treat as a glitch. Go to IDLE with no flag raised.
  - Sample 0: go to DATA.
- DATA: every `CLKS_PER_BIT` cycles, sample one bit and shift it into the MSB of the shift register, so the first bit received ends at the LSB. After `DATA_BITS` samples, go to PARITY or STOP.
- PARITY: after one bit period, sample and check even parity across data plus parity bit. Store the result and go to STOP.
- STOP: after one bit period, sample.
  - Sample 1: load `rx_data` and pulse `rx_valid`. If parity was bad, pulse `rx_parity_err` in the same cycle.
  - Sample 0: pulse `rx_frame_err`. `rx_data` and `rx_valid` are untouched.
  - In both cases go to IDLE the next cycle, at mid-stop. This leaves half a bit of slack to catch the next start edge.
- A new falling edge during any non-IDLE state is ignored.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide and reloads to 0 on every sample.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `rx_data` = 0; `rx_valid`, `rx_frame_err`, `rx_parity_err` and `rx_busy` = 0.
  - Synchronizer and `rx_prev` = 1.
- Reset asserted mid-frame aborts the frame immediately, with no pulse. After release the block waits for a fresh falling edge.
- Edge detect lags the pin by 2 synchronizer cycles plus 1 cycle.
- Latency is about `(DATA_BITS+1.5+P)*CLKS_PER_BIT + 4` cycles from the start-bit edge at the pin to `rx_valid`, where P = 1 with parity, else 0.
- `rx_valid`, `rx_frame_err` and `rx_parity_err` are registered outputs, high for exactly one cycle.
- There is no backpressure. A consumer that misses `rx_valid` loses the byte, but `rx_data` stays readable until the next valid frame.
- `rx_busy` rises the cycle after edge detect and falls on the cycle the pulse is issued.

## Configuration
- `RX_IEEE_PARITY_EN` defined:
  - The PARITY state and the even-parity check are built.
  - The frame is start + `DATA_BITS` + parity + stop.
  - `rx_parity_err` is live.
- Not defined:
  - There is no PARITY state; the frame is 8-N-1.
  - `rx_parity_err` is constant 0.
  - Port list is identical in both builds.

## Structure
- A shared package `ieee_uart_pkg` holds:
  - the state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP), shared with the transmitter;
  - `DEFAULT_CLKS_PER_BIT` = 868;
  - `UART_IDLE_LVL` = 1'b1.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with a reset value parameter.
- The FSM, counters and shift register stay in `rx_ieee`.

## Test plan
All scenarios use `CLKS_PER_BIT`=10, 10 ns clock, and the line driven by a bench bit-banger.
- Send 0xA5 as 8-N-1 -> exactly one `rx_valid` pulse with `rx_data`=0xA5; `rx_frame_err`=0; `rx_busy` low afterwards.
- Send back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three `rx_valid` pulses, about 100 cycles apart, with matching data.
- Drive a 3-cycle low glitch on an idle line -> no `rx_valid`, no `rx_frame_err`; the block returns to IDLE within 8 cycles.
- Send 0x55 with the stop bit forced low, then hold the line low for 50 cycles -> one `rx_frame_err` pulse, `rx_data` unchanged, no retrigger until the line goes high then low.
- Assert `reset` for 1 cycle mid-DATA during 0x81, then send 0x42 -> no pulse for 0x81; `rx_valid` with 0x42.
- With `RX_IEEE_PARITY_EN`, send 0x07 with a parity bit of 0 (wrong) -> `rx_valid` and `rx_parity_err` pulse together, `rx_data`=0x07. Send 0x07 with a parity bit of 1 -> `rx_parity_err`=0.
